// File: rtl/sram_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_burst_ctrl_if
// Brief    : Pipeline-side request/response bundle for sram_burst_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_burst_ctrl_if #(
    parameter int WORD_W = 32
);
    logic              rd_en;
    logic              wr_en;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              ready;

    modport master (
        output rd_en, wr_en, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  rd_en, wr_en, addr, wdata,
        output rdata, ready
    );
endinterface
`default_nettype wire

// File: rtl/sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_burst_ctrl
// Brief    : Splits one pipeline word access into a burst of narrow SRAM beats.
// Revision : 1.0 - initial release
// ============================================================================
module sram_burst_ctrl #(
    parameter int WORD_W    = 32,
    parameter int SRAM_DW   = 16,
    parameter int SRAM_AW   = 18,
    parameter int WAIT_CYC  = 1,
    parameter int BASE_ADDR = 1024
) (
    input  wire logic               clk,
    input  wire logic               rst,
    sram_burst_ctrl_if.slave        bus,
    inout  wire       [SRAM_DW-1:0] SRAM_DQ,
    output logic      [SRAM_AW-1:0] SRAM_ADDR,
    output logic                    SRAM_UB_N,
    output logic                    SRAM_LB_N,
    output logic                    SRAM_WE_N,
    output logic                    SRAM_CE_N,
    output logic                    SRAM_OE_N
);

    localparam int c_BEATS   = WORD_W / SRAM_DW;
    localparam int c_BEAT_W  = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_BYTE_SH = $clog2(WORD_W / 8);
    localparam int c_BEAT_SH = $clog2(c_BEATS);

    localparam logic [3:0]          c_WAIT_LAST = 4'(WAIT_CYC);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(c_BEATS - 1);
    localparam logic [31:0]         c_BASE      = 32'(BASE_ADDR);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]          r_state;
    logic                r_op_wr;
    logic [31:0]         r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic [WORD_W-1:0]   r_rdata;
    logic [c_BEAT_W-1:0] r_beat;
    logic [3:0]          r_wait;
    logic                r_we_n;
    logic                r_oe_n;
    logic                r_ce_n;
    logic                r_dq_oe;

    logic                w_req;
    logic                w_ready;

    assign w_req = bus.rd_en | bus.wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_beat  <= '0;
            r_wait  <= '0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ce_n  <= 1'b1;
            r_dq_oe <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // A simultaneous read and write request resolves to the write.
                        r_op_wr <= bus.wr_en;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_beat  <= '0;
                        r_wait  <= '0;
                        r_we_n  <= ~bus.wr_en;
                        r_oe_n  <= bus.wr_en;
                        r_ce_n  <= 1'b0;
                        r_dq_oe <= bus.wr_en;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_wait == c_WAIT_LAST) begin
                        r_wait <= '0;
                        if (!r_op_wr) begin
                            r_rdata[r_beat*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
                        end
                        if (r_beat == c_BEAT_LAST) begin
                            r_we_n  <= 1'b1;
                            r_oe_n  <= 1'b1;
                            r_ce_n  <= 1'b1;
                            r_dq_oe <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_beat <= r_beat + c_BEAT_W'(1);
                        end
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Idle ready is combinational so a new request freezes the pipeline in the same cycle.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_IDLE:   w_ready = ~w_req;
            S_ACCESS: w_ready = 1'b0;
            S_DONE:   w_ready = 1'b1;
            default:  w_ready = 1'b0;
        endcase
    end

    assign bus.ready = w_ready;
    assign bus.rdata = r_rdata;

    assign SRAM_DQ   = r_dq_oe ? r_wdata[r_beat*SRAM_DW +: SRAM_DW] : {SRAM_DW{1'bz}};
    assign SRAM_ADDR = SRAM_AW'(((r_addr - c_BASE) >> c_BYTE_SH) << c_BEAT_SH) + SRAM_AW'(r_beat);
    assign SRAM_WE_N = r_we_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_CE_N = r_ce_n;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_burst_ctrl
// Brief    : Randomized scoreboard bench for sram_burst_ctrl with an SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_burst_ctrl;

    localparam int c_WAIT  = 1;
    localparam int c_BEATS = 2;
    localparam int c_LOW   = 1 + c_BEATS * (c_WAIT + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- main DUT (WAIT_CYC = 1) ----------------
    sram_burst_ctrl_if #(.WORD_W(32)) pipe ();
    wire  [15:0] dq;
    logic [17:0] sa;
    logic        ub, lb, we, ce, oe;

    sram_burst_ctrl #(
        .WORD_W(32), .SRAM_DW(16), .SRAM_AW(18), .WAIT_CYC(c_WAIT), .BASE_ADDR(1024)
    ) dut (
        .clk(clk), .rst(rst), .bus(pipe),
        .SRAM_DQ(dq), .SRAM_ADDR(sa),
        .SRAM_UB_N(ub), .SRAM_LB_N(lb), .SRAM_WE_N(we), .SRAM_CE_N(ce), .SRAM_OE_N(oe)
    );

    // ---------------- second DUT (WAIT_CYC = 0) ----------------
    sram_burst_ctrl_if #(.WORD_W(32)) p0 ();
    wire  [15:0] dq0;
    logic [17:0] sa0;
    logic        ub0, lb0, we0, ce0, oe0;

    sram_burst_ctrl #(
        .WORD_W(32), .SRAM_DW(16), .SRAM_AW(18), .WAIT_CYC(0), .BASE_ADDR(1024)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(p0),
        .SRAM_DQ(dq0), .SRAM_ADDR(sa0),
        .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_WE_N(we0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
    );

    function automatic logic [15:0] pre(input int a);
        return 16'(a * 40503 + 4660);
    endfunction

    // SRAM device models; an undriven bus floats high through the pull-ups.
    logic [15:0] sram_mem [0:262143];
    assign dq  = (!oe && !ce && we) ? sram_mem[sa] : 16'hzzzz;
    assign dq0 = (!oe0 && !ce0) ? pre(int'(sa0)) : 16'hzzzz;
    pullup pu_dq  (dq);
    pullup pu_dq0 (dq0);

    always @(posedge clk) begin
        if (!we && !ce) sram_mem[sa] <= dq;
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct { logic [31:0] rdata; int low; } txn_t;
    typedef struct { logic [17:0] a; logic [15:0] d; } beat_t;

    txn_t        txn_q [$];
    beat_t       wbeat_q [$];
    logic [17:0] rbeat_q [$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd;

    int n_checks = 0;
    int n_fail   = 0;
    int lowcnt   = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off >> 2) & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return {pre(2 * w + 1), pre(2 * w)};
    endfunction

    // Called at posedge+1; returns at posedge+1 following the DONE cycle.
    task automatic run_op(input bit do_wr, input bit do_rd, input logic [31:0] a, input logic [31:0] d);
        int   w;
        txn_t t;
        bit   done;
        w = word_of(a);
        pipe.rd_en = do_rd;
        pipe.wr_en = do_wr;
        pipe.addr  = a;
        pipe.wdata = d;
        t.low = c_LOW;
        if (do_wr) begin
            ref_mem[w] = d;
            for (int k = 0; k < c_BEATS; k++)
                for (int c = 0; c <= c_WAIT; c++)
                    wbeat_q.push_back('{a: 18'(2 * w + k), d: d[16*k +: 16]});
            t.rdata = last_rd;
        end else begin
            last_rd = ref_word(w);
            for (int k = 0; k < c_BEATS; k++)
                for (int c = 0; c <= c_WAIT; c++)
                    rbeat_q.push_back(18'(2 * w + k));
            t.rdata = last_rd;
        end
        txn_q.push_back(t);
        @(posedge clk); #1;
        // Inputs after the latch must have no effect on the operation.
        if ($urandom_range(0, 1) == 1) begin
            pipe.rd_en = 1'($urandom);
            pipe.wr_en = 1'($urandom);
            pipe.addr  = $urandom;
            pipe.wdata = $urandom;
        end
        done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (pipe.ready) begin
                done = 1'b1;
                break;
            end
        end
        chk("req_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        pipe.rd_en = 1'b0;
        pipe.wr_en = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a completion or an SRAM beat.
    always @(negedge clk) begin
        txn_t  t;
        beat_t b;
        logic [17:0] ea;
        if (mon_en) begin
            if (!pipe.ready) begin
                lowcnt++;
            end else if (lowcnt > 0) begin
                if (txn_q.size() == 0) begin
                    chk("txn_unexpected", 64'd1, 64'd0);
                end else begin
                    t = txn_q.pop_front();
                    chk("ready_low_cycles", 64'(lowcnt), 64'(t.low));
                    chk("rdata", 64'(pipe.rdata), 64'(t.rdata));
                end
                lowcnt = 0;
            end else begin
                chk("idle_strobes_ce_we_oe", {61'd0, ce, we, oe}, 64'h7);
                chk("idle_dq_hiz", 64'(dq), 64'hFFFF);
                chk("ub_lb", {62'd0, ub, lb}, 64'd0);
            end
            if (!we) begin
                if (wbeat_q.size() == 0) begin
                    chk("wr_beat_unexpected", 64'd1, 64'd0);
                end else begin
                    b = wbeat_q.pop_front();
                    chk("wr_addr", 64'(sa), 64'(b.a));
                    chk("wr_dq", 64'(dq), 64'(b.d));
                    chk("wr_ce_oe", {62'd0, ce, oe}, 64'd1);
                end
            end
            if (!oe) begin
                if (rbeat_q.size() == 0) begin
                    chk("rd_beat_unexpected", 64'd1, 64'd0);
                end else begin
                    ea = rbeat_q.pop_front();
                    chk("rd_addr", 64'(sa), 64'(ea));
                    chk("rd_ce_we", {62'd0, ce, we}, 64'd1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int low0;
        logic [17:0] seq0 [$];
        bit done0;

        rst = 1'b0;
        pipe.rd_en = 1'b0; pipe.wr_en = 1'b0; pipe.addr = '0; pipe.wdata = '0;
        p0.rd_en   = 1'b0; p0.wr_en   = 1'b0; p0.addr   = '0; p0.wdata   = '0;
        last_rd = '0;
        for (int i = 0; i < 262144; i++) sram_mem[i] = pre(i);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(pipe.ready), 64'd1);
        chk("rst_strobes_ce_we_oe", {61'd0, ce, we, oe}, 64'h7);
        chk("rst_dq_hiz", 64'(dq), 64'hFFFF);
        chk("rst_rdata", 64'(pipe.rdata), 64'd0);
        chk("rst_ready_w0", 64'(p0.ready), 64'd1);
        pipe.rd_en = 1'b1; #1;
        chk("rst_ready_follows_req", 64'(pipe.ready), 64'd0);
        pipe.rd_en = 1'b0; #1;
        chk("rst_ready_follows_noreq", 64'(pipe.ready), 64'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Directed cases, then randomized traffic
        run_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        run_op(1'b0, 1'b1, 32'd1024, 32'h0);
        run_op(1'b1, 1'b1, 32'd1028, 32'h12345678);
        run_op(1'b0, 1'b1, 32'd1028, 32'h0);
        run_op(1'b0, 1'b1, 32'd1100, 32'h0);
        run_op(1'b1, 1'b0, 32'd1020, 32'hA5A55A5A);
        run_op(1'b0, 1'b1, 32'd1020, 32'h0);
        for (int i = 0; i < 60; i++) begin
            int op;
            int gap;
            op  = $urandom_range(0, 2);
            gap = $urandom_range(0, 2);
            run_op(op != 0, op != 1, 32'd1024 + 32'(4 * $urandom_range(0, 63)), $urandom);
            repeat (gap) begin @(posedge clk); #1; end
        end

        // Reset during beat 1 of a write
        mon_en = 1'b0;
        pipe.wr_en = 1'b1; pipe.addr = 32'd1824; pipe.wdata = 32'hCAFEF00D;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrst_pre_we", 64'(we), 64'd0);
        chk("midrst_pre_addr", 64'(sa), 64'd401);
        chk("midrst_pre_dq", 64'(dq), 64'hCAFE);
        rst = 1'b0; #1;
        chk("midrst_strobes_ce_we_oe", {61'd0, ce, we, oe}, 64'h7);
        chk("midrst_dq_hiz", 64'(dq), 64'hFFFF);
        chk("midrst_rdata", 64'(pipe.rdata), 64'd0);
        chk("midrst_ready_req", 64'(pipe.ready), 64'd0);
        pipe.wr_en = 1'b0; #1;
        chk("midrst_ready_noreq", 64'(pipe.ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        last_rd = '0;
        lowcnt = 0;
        mon_en = 1'b1;
        run_op(1'b0, 1'b1, 32'd1044, 32'h0);
        repeat (3) begin @(posedge clk); #1; end
        mon_en = 1'b0;
        chk("txn_q_drained", 64'(txn_q.size()), 64'd0);
        chk("wbeat_q_drained", 64'(wbeat_q.size()), 64'd0);
        chk("rbeat_q_drained", 64'(rbeat_q.size()), 64'd0);

        // Zero-wait build: read at 1024
        p0.rd_en = 1'b1; p0.addr = 32'd1024;
        low0 = 0; done0 = 1'b0;
        for (n0 = 0; n0 < 20; n0++) begin
            @(negedge clk);
            if (!oe0) seq0.push_back(sa0);
            if (p0.ready) begin
                done0 = 1'b1;
                break;
            end
            low0++;
        end
        chk("w0_done", 64'(done0), 64'd1);
        chk("w0_ready_low_cycles", 64'(low0), 64'd3);
        chk("w0_beats", 64'(seq0.size()), 64'd2);
        if (seq0.size() == 2) begin
            chk("w0_addr0", 64'(seq0[0]), 64'd0);
            chk("w0_addr1", 64'(seq0[1]), 64'd1);
        end
        chk("w0_rdata", 64'(p0.rdata), {32'd0, pre(1), pre(0)});
        @(posedge clk); #1;
        p0.rd_en = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_burst_ctrl.md
SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 Parameter WORD_W, default 32: width in bits of the pipeline-side data word.
REQ-002 Parameter SRAM_DW, default 16: width in bits of the SRAM data bus; WORD_W SHALL be an integer multiple of SRAM_DW, and BEATS = WORD_W/SRAM_DW SHALL be a power of two.
REQ-003 Parameter SRAM_AW, default 18: width in bits of the SRAM address bus.
REQ-004 Parameter WAIT_CYC, default 1, range 0..15: extra wait cycles inserted per SRAM beat.
REQ-005 Parameter BASE_ADDR, default 1024: byte address that maps to SRAM word 0.
REQ-006 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 rd_en  input  1  read request, held by the pipeline until ready is observed high.
REQ-009 wr_en  input  1  write request, held by the pipeline until ready is observed high.
REQ-010 addr  input  32  byte address of the request.
REQ-011 wdata  input  WORD_W  write data.
REQ-012 rdata  output  WORD_W  data from the last completed read.
REQ-013 ready  output  1  0 = freeze the pipeline; 1 = no access pending, or access complete.
REQ-014 SRAM_DQ  inout  SRAM_DW  bidirectional SRAM data bus.
REQ-015 SRAM_ADDR  output  SRAM_AW  SRAM beat address.
REQ-016 SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  output  1 each  active-low SRAM strobes.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-018 In IDLE, ready SHALL equal ~(rd_en|wr_en) combinationally.
REQ-019 In IDLE with rd_en|wr_en asserted, the next edge SHALL latch op (write if wr_en, else read), addr and wdata, clear the beat and wait counters, and enter ACCESS.
REQ-020 Simultaneous rd_en and wr_en SHALL be treated as a write.
REQ-021 Changes on rd_en, wr_en, addr or wdata after the latch SHALL be ignored until the FSM next enters IDLE.
REQ-022 Deasserting the request mid-operation SHALL NOT abort the operation.
REQ-023 In ACCESS, ready SHALL be 0 and each beat SHALL last WAIT_CYC+1 cycles; the wait counter counts 0..WAIT_CYC, then the beat counter increments.
REQ-024 After the last cycle of beat BEATS-1, the FSM SHALL enter DONE.
REQ-025 In DONE, ready SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-026 Latency: ready SHALL be low for exactly 1+BEATS*(WAIT_CYC+1) consecutive cycles per request.
REQ-027 SRAM_ADDR SHALL be ((addr_latched-BASE_ADDR)>>log2(WORD_W/8))*BEATS + beat, truncated to SRAM_AW bits; wrap-around SHALL be modulo 2^SRAM_AW.
REQ-028 Beat k SHALL carry data bits [(k+1)*SRAM_DW-1 : k*SRAM_DW], so beat 0 is the least-significant slice.
REQ-029 During a write ACCESS, SRAM_DQ SHALL be driven with the beat-k slice of wdata; in every other state or op it SHALL be high-Z.
REQ-030 SRAM_WE_N SHALL be 0 only during write ACCESS, and 1 otherwise.
REQ-031 SRAM_OE_N SHALL be 0 only during read ACCESS, and 1 otherwise.
REQ-032 SRAM_CE_N SHALL be 0 in ACCESS, and 1 otherwise.
REQ-033 SRAM_UB_N and SRAM_LB_N SHALL be constant 0.
REQ-034 During a read, on the edge ending the last wait cycle of beat k, SRAM_DQ SHALL be captured into the beat-k slice of rdata.
REQ-035 rdata SHALL hold its value until the next read captures new data; writes SHALL NOT alter rdata.
REQ-036 Back-to-back requests: the cycle after DONE is IDLE, so a still-asserted new request SHALL drop ready immediately with no idle-high cycle.

Reset
REQ-037 When rst=0, the block SHALL asynchronously enter IDLE.
REQ-038 Reset SHALL clear the counters and latched op/addr/wdata, and SHALL set rdata=0, SRAM_DQ to high-Z, SRAM_WE_N=1, SRAM_OE_N=1 and SRAM_CE_N=1.
REQ-039 During reset, ready SHALL follow REQ-018.
REQ-040 Reset asserted mid-operation SHALL abort the beat in progress, with no further SRAM strobes issued.
REQ-041 After reset release, the first request SHALL start a fresh operation.

Verification (defaults: BEATS=2, WAIT_CYC=1)
REQ-042 Idle: rd_en=wr_en=0 -> ready=1, SRAM_CE_N=1, SRAM_DQ=Z.
REQ-043 Write: wr_en=1, addr=1024, wdata=0xDEADBEEF -> ready low for 5 cycles; SRAM_ADDR=0 with DQ=0xBEEF, then SRAM_ADDR=1 with DQ=0xDEAD; WE_N low for 4 cycles.
REQ-044 Read back: rd_en=1, addr=1024 with the SRAM model preloaded -> rdata=0xDEADBEEF in the DONE cycle, with ready=1 for that cycle.
REQ-045 Address mapping and priority: rd_en=wr_en=1, addr=1028, wdata=0x12345678 -> write to SRAM_ADDR 2 (0x5678) and 3 (0x1234); rdata unchanged.
REQ-046 WAIT_CYC=0 build: a read at addr 1024 -> ready low for 3 cycles, SRAM_ADDR sequence 0,1.
REQ-047 Reset mid-write: rst=0 in beat 1 -> WE_N=1, CE_N=1 and DQ=Z immediately; after release, a new read completes correctly in 5 cycles.
